// File: rtl/pipe_phy_cmd_responder.sv
// PHY-side PIPE command responder: answers receiver-detect, rate and powerdown
// requests from the MAC with lock-step PhyStatus pulses and RxStatus codes.
//
// state  | meaning
// RESET  | PHY leaving reset, phystatus/phystatus_rst held high for RESET_LATENCY
// IDLE   | waiting for a detect edge or a rate/powerdown mismatch
// DETECT | receiver detect in progress, pulse reports per-lane presence
// RATE   | rate change in progress, rate_o updates with the pulse
// PWR    | power state change in progress, powerdown_o updates with the pulse
module pipe_phy_cmd_responder #(
    parameter int MAX_NUM_LANES  = 8,
    parameter int RESET_LATENCY  = 32,
    parameter int DETECT_LATENCY = 16,
    parameter int RATE_LATENCY   = 24,
    parameter int PWR_LATENCY    = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [MAX_NUM_LANES-1:0]   lane_present_i,
    input  logic                       phy_txdetectrx_i,
    input  logic [MAX_NUM_LANES-1:0]   phy_txelecidle_i,
    input  logic [2:0]                 phy_rate_i,
    input  logic [1:0]                 phy_powerdown_i,
    output logic [MAX_NUM_LANES-1:0]   phy_phystatus_o,
    output logic [3*MAX_NUM_LANES-1:0] phy_rxstatus_o,
    output logic                       phy_phystatus_rst_o,
    output logic [2:0]                 rate_o,
    output logic [1:0]                 powerdown_o,
    output logic                       busy_o
);

    localparam int LAT_A   = (RESET_LATENCY > DETECT_LATENCY) ? RESET_LATENCY : DETECT_LATENCY;
    localparam int LAT_B   = (RATE_LATENCY > PWR_LATENCY) ? RATE_LATENCY : PWR_LATENCY;
    localparam int MAX_LAT = (LAT_A > LAT_B) ? LAT_A : LAT_B;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [CNT_W-1:0] CNT_RST  = CNT_W'(RESET_LATENCY);
    localparam logic [CNT_W-1:0] CNT_DET  = CNT_W'(DETECT_LATENCY);
    localparam logic [CNT_W-1:0] CNT_RATE = CNT_W'(RATE_LATENCY);
    localparam logic [CNT_W-1:0] CNT_PWR  = CNT_W'(PWR_LATENCY);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_RESET,
        ST_IDLE,
        ST_DETECT,
        ST_RATE,
        ST_PWR
    } state_t;

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       det_prev_q, det_prev_d;
    logic [MAX_NUM_LANES-1:0]   phystatus_q, phystatus_d;
    logic [3*MAX_NUM_LANES-1:0] rxstatus_q, rxstatus_d;
    logic                       phystatus_rst_q, phystatus_rst_d;
    logic [2:0]                 rate_q, rate_d;
    logic [1:0]                 pwr_q, pwr_d;
    logic [2:0]                 rate_tgt_q, rate_tgt_d;
    logic [1:0]                 pwr_tgt_q, pwr_tgt_d;
    logic                       busy_q, busy_d;
    logic                       det_req;

    // Only a fresh rising edge with every lane idle counts as a detect request.
    assign det_req = phy_txdetectrx_i & ~det_prev_q & (&phy_txelecidle_i);

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        det_prev_d      = phy_txdetectrx_i;
        phystatus_d     = '0;
        rxstatus_d      = '0;
        phystatus_rst_d = phystatus_rst_q;
        rate_d          = rate_q;
        pwr_d           = pwr_q;
        rate_tgt_d      = rate_tgt_q;
        pwr_tgt_d       = pwr_tgt_q;

        case (state_q)
            ST_RESET: begin
                if (cnt_q == CNT_ONE) begin
                    state_d         = ST_IDLE;
                    phystatus_rst_d = 1'b0;
                end else begin
                    cnt_d       = cnt_q - CNT_ONE;
                    phystatus_d = '1;
                end
            end
            ST_IDLE: begin
                if (det_req) begin
                    state_d = ST_DETECT;
                    cnt_d   = CNT_DET;
                end else if (phy_rate_i != rate_q) begin
                    state_d    = ST_RATE;
                    cnt_d      = CNT_RATE;
                    rate_tgt_d = phy_rate_i;
                end else if (phy_powerdown_i != pwr_q) begin
                    state_d   = ST_PWR;
                    cnt_d     = CNT_PWR;
                    pwr_tgt_d = phy_powerdown_i;
                end
            end
            ST_DETECT, ST_RATE, ST_PWR: begin
                // cnt==1 schedules the pulse; cnt==0 is the pulse cycle itself.
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_ONE) begin
                    cnt_d       = '0;
                    phystatus_d = '1;
                    if (state_q == ST_DETECT) begin
                        for (int i = 0; i < MAX_NUM_LANES; i++) begin
                            rxstatus_d[3*i +: 3] = lane_present_i[i] ? 3'b011 : 3'b000;
                        end
                    end else if (state_q == ST_RATE) begin
                        rate_d = rate_tgt_q;
                    end else begin
                        pwr_d = pwr_tgt_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_RESET;
                cnt_d   = CNT_RST;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= ST_RESET;
            cnt_q           <= CNT_RST;
            det_prev_q      <= 1'b0;
            phystatus_q     <= '1;
            rxstatus_q      <= '0;
            phystatus_rst_q <= 1'b1;
            rate_q          <= 3'd0;
            pwr_q           <= 2'b10;
            rate_tgt_q      <= 3'd0;
            pwr_tgt_q       <= 2'b10;
            busy_q          <= 1'b1;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            det_prev_q      <= det_prev_d;
            phystatus_q     <= phystatus_d;
            rxstatus_q      <= rxstatus_d;
            phystatus_rst_q <= phystatus_rst_d;
            rate_q          <= rate_d;
            pwr_q           <= pwr_d;
            rate_tgt_q      <= rate_tgt_d;
            pwr_tgt_q       <= pwr_tgt_d;
            busy_q          <= busy_d;
        end
    end

    assign phy_phystatus_o     = phystatus_q;
    assign phy_rxstatus_o      = rxstatus_q;
    assign phy_phystatus_rst_o = phystatus_rst_q;
    assign rate_o              = rate_q;
    assign powerdown_o         = pwr_q;
    assign busy_o              = busy_q;

endmodule

// File: tb/tb_pipe_phy_cmd_responder.sv
// Scoreboard bench for pipe_phy_cmd_responder: a transaction-level model predicts
// each PhyStatus pulse (edge, rxstatus, applied rate/power) and a monitor checks them.
module tb_pipe_phy_cmd_responder;

    localparam int N        = 8;
    localparam int RST_LAT  = 32;
    localparam int DET_LAT  = 16;
    localparam int RATE_LAT = 24;
    localparam int PWR_LAT  = 8;
    localparam int ALL_ONES = (1 << N) - 1;

    logic           clk_i = 1'b0;
    logic           rst_ni;
    logic [N-1:0]   lane_present_i;
    logic           phy_txdetectrx_i;
    logic [N-1:0]   phy_txelecidle_i;
    logic [2:0]     phy_rate_i;
    logic [1:0]     phy_powerdown_i;
    logic [N-1:0]   phy_phystatus_o;
    logic [3*N-1:0] phy_rxstatus_o;
    logic           phy_phystatus_rst_o;
    logic [2:0]     rate_o;
    logic [1:0]     powerdown_o;
    logic           busy_o;

    always #5 clk_i = ~clk_i;

    pipe_phy_cmd_responder #(
        .MAX_NUM_LANES (N),
        .RESET_LATENCY (RST_LAT),
        .DETECT_LATENCY(DET_LAT),
        .RATE_LATENCY  (RATE_LAT),
        .PWR_LATENCY   (PWR_LAT)
    ) dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .lane_present_i     (lane_present_i),
        .phy_txdetectrx_i   (phy_txdetectrx_i),
        .phy_txelecidle_i   (phy_txelecidle_i),
        .phy_rate_i         (phy_rate_i),
        .phy_powerdown_i    (phy_powerdown_i),
        .phy_phystatus_o    (phy_phystatus_o),
        .phy_rxstatus_o     (phy_rxstatus_o),
        .phy_phystatus_rst_o(phy_phystatus_rst_o),
        .rate_o             (rate_o),
        .powerdown_o        (powerdown_o),
        .busy_o             (busy_o)
    );

    int tests = 0;
    int fails = 0;
    int edge_cnt = 0;

    always @(posedge clk_i) edge_cnt++;

    typedef struct {
        int             edge_no;
        logic [3*N-1:0] rx;
        logic [2:0]     rate;
        logic [1:0]     pwr;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    // Reference model: applied settings, last detect level, first edge at which a new request may be taken.
    logic       m_prev_tx;
    logic [2:0] m_rate;
    logic [1:0] m_pwr;
    int         m_free;
    bit         m_in_reset = 1'b1;

    task automatic chk(string name, int act, int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h (edge %0d)", name, act, expv, edge_cnt);
        end
    endtask

    function automatic logic [3*N-1:0] detect_code(logic [N-1:0] present);
        logic [3*N-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) if (present[i]) r[3*i +: 3] = 3'b011;
        return r;
    endfunction

    // Called at the negedge once the inputs for the coming posedge are settled.
    task automatic model_step();
        int   k;
        exp_t e;
        k = edge_cnt + 1;
        if (!rst_ni) begin
            m_prev_tx  = 1'b0;
            m_rate     = 3'd0;
            m_pwr      = 2'b10;
            m_in_reset = 1'b1;
            m_free     = 0;
            exp_q.delete();
            return;
        end
        if (m_in_reset) begin
            m_free     = k + RST_LAT;
            m_in_reset = 1'b0;
        end
        if (k >= m_free) begin
            if (phy_txdetectrx_i && !m_prev_tx && (&phy_txelecidle_i)) begin
                e.edge_no = k + DET_LAT;
                e.rx = detect_code(lane_present_i);
                e.rate = m_rate;
                e.pwr = m_pwr;
                exp_q.push_back(e);
                m_free = k + DET_LAT + 2;
            end else if (phy_rate_i != m_rate) begin
                m_rate = phy_rate_i;
                e.edge_no = k + RATE_LAT;
                e.rx = '0;
                e.rate = m_rate;
                e.pwr = m_pwr;
                exp_q.push_back(e);
                m_free = k + RATE_LAT + 2;
            end else if (phy_powerdown_i != m_pwr) begin
                m_pwr = phy_powerdown_i;
                e.edge_no = k + PWR_LAT;
                e.rx = '0;
                e.rate = m_rate;
                e.pwr = m_pwr;
                exp_q.push_back(e);
                m_free = k + PWR_LAT + 2;
            end
        end
        m_prev_tx = phy_txdetectrx_i;
    endtask

    task automatic step(logic tx, logic [N-1:0] idle, logic [2:0] rate, logic [1:0] pwr);
        @(negedge clk_i);
        phy_txdetectrx_i = tx;
        phy_txelecidle_i = idle;
        phy_rate_i       = rate;
        phy_powerdown_i  = pwr;
        model_step();
    endtask

    task automatic hold(int n);
        repeat (n) begin
            @(negedge clk_i);
            model_step();
        end
    endtask

    task automatic check_reset_values(string tag);
        chk({tag, "_phystatus"}, int'(phy_phystatus_o), ALL_ONES);
        chk({tag, "_phystatus_rst"}, int'(phy_phystatus_rst_o), 1);
        chk({tag, "_rxstatus"}, int'(phy_rxstatus_o), 0);
        chk({tag, "_busy"}, int'(busy_o), 1);
        chk({tag, "_rate"}, int'(rate_o), 0);
        chk({tag, "_powerdown"}, int'(powerdown_o), 2);
    endtask

    task automatic release_and_check_reset_seq();
        @(negedge clk_i);
        rst_ni = 1'b1;
        model_step();
        for (int i = 1; i <= RST_LAT; i++) begin
            @(posedge clk_i);
            #1;
            if (i == RST_LAT - 1) begin
                chk("rst_seq_rst_high", int'(phy_phystatus_rst_o), 1);
                chk("rst_seq_phystatus_high", int'(phy_phystatus_o), ALL_ONES);
            end
            if (i == RST_LAT) begin
                chk("rst_seq_rst_low", int'(phy_phystatus_rst_o), 0);
                chk("rst_seq_phystatus_low", int'(phy_phystatus_o), 0);
                chk("rst_seq_busy_low", int'(busy_o), 0);
            end
            if (i < RST_LAT) begin
                @(negedge clk_i);
                model_step();
            end
        end
    endtask

    // Monitor: pops an expectation whenever the DUT presents a PhyStatus pulse.
    always @(posedge clk_i) begin
        #1;
        if (rst_ni && !phy_phystatus_rst_o) begin
            while (exp_q.size() > 0 && exp_q[0].edge_no < edge_cnt) begin
                tests++;
                fails++;
                $display("FAIL missed_pulse: no phystatus at edge %0d, required pulse (now edge %0d)",
                         exp_q[0].edge_no, edge_cnt);
                void'(exp_q.pop_front());
            end
            if (phy_phystatus_o != '0) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_pulse: phystatus=%0h rxstatus=%0h at edge %0d, required no pulse",
                             phy_phystatus_o, phy_rxstatus_o, edge_cnt);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("pulse_edge", edge_cnt, mon_e.edge_no);
                    chk("pulse_lanes", int'(phy_phystatus_o), ALL_ONES);
                    chk("pulse_rxstatus", int'(phy_rxstatus_o), int'(mon_e.rx));
                    chk("pulse_rate", int'(rate_o), int'(mon_e.rate));
                    chk("pulse_powerdown", int'(powerdown_o), int'(mon_e.pwr));
                    chk("pulse_busy", int'(busy_o), 1);
                end
            end else begin
                chk("rxstatus_quiet", int'(phy_rxstatus_o), 0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic         tx;
        logic [N-1:0] idle;
        logic [2:0]   rate;
        logic [1:0]   pwr;

        rst_ni           = 1'b1;
        lane_present_i   = 8'h0F;
        phy_txdetectrx_i = 1'b0;
        phy_txelecidle_i = '1;
        phy_rate_i       = 3'd0;
        phy_powerdown_i  = 2'd0;
        #2;
        rst_ni = 1'b0;
        hold(3);
        #1;
        check_reset_values("reset");

        // Release: 32-cycle reset sequence, then powerdown 0 is applied.
        release_and_check_reset_seq();
        hold(15);
        chk("init_powerdown", int'(powerdown_o), 0);

        // Receiver detect with lanes 0-3 present.
        step(1'b1, '1, 3'd0, 2'd0);
        hold(22);
        step(1'b0, '1, 3'd0, 2'd0);
        hold(3);

        // Detect edge while one lane is not idle: ignored.
        step(1'b1, 8'hFE, 3'd0, 2'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk_i);
            #1;
            chk("no_detect_busy", int'(busy_o), 0);
            hold(1);
        end
        step(1'b1, '1, 3'd0, 2'd0);
        hold(3);
        chk("held_high_busy", int'(busy_o), 0);
        step(1'b0, '1, 3'd0, 2'd0);

        // Simultaneous detect edge and rate request: detect first, rate after.
        step(1'b1, '1, 3'd1, 2'd0);
        hold(50);
        chk("simul_rate", int'(rate_o), 1);

        // Rate changed again while a rate run is in flight.
        step(1'b0, '1, 3'd0, 2'd0);
        hold(30);
        step(1'b0, '1, 3'd1, 2'd0);
        hold(5);
        step(1'b0, '1, 3'd2, 2'd0);
        hold(60);
        chk("rate_second_run", int'(rate_o), 2);

        // Reset in the middle of a detect run.
        step(1'b1, '1, 3'd2, 2'd0);
        hold(6);
        @(negedge clk_i);
        rst_ni = 1'b0;
        model_step();
        #1;
        check_reset_values("mid_reset");
        hold(2);
        release_and_check_reset_seq();
        step(1'b0, '1, 3'd2, 2'd0);
        hold(70);
        chk("post_reset_rate", int'(rate_o), 2);
        chk("post_reset_powerdown", int'(powerdown_o), 0);

        // Randomized traffic.
        lane_present_i = N'($urandom);
        tx   = 1'b0;
        rate = 3'd2;
        pwr  = 2'd0;
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 3) == 0) tx = ~tx;
            idle = ($urandom_range(0, 7) == 0) ? N'($urandom) : '1;
            if ($urandom_range(0, 39) == 0) rate = 3'($urandom_range(0, 4));
            if ($urandom_range(0, 39) == 0) pwr = 2'($urandom_range(0, 3));
            step(tx, idle, rate, pwr);
        end
        step(1'b0, '1, rate, pwr);
        hold(120);
        chk("drained", exp_q.size(), 0);
        chk("final_rate", int'(rate_o), int'(m_rate));
        chk("final_powerdown", int'(powerdown_o), int'(m_pwr));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
